// File: rtl/hdmi_island_scheduler.sv
// HDMI data island scheduler: frames islands inside blanking and picks which
// pending packet source owns each 32-cycle packet slot (lowest index first).
module hdmi_island_scheduler #(
  parameter int                 NUM_SRC     = 4,
  parameter logic [NUM_SRC-1:0] FIELD_MASK  = 4'b1100,
  parameter int                 MAX_PACKETS = 18,
  parameter int                 MIN_GAP     = 12,
  parameter int                 CNT_W       = 12
) (
  input  logic                                    clk_pixel,
  input  logic                                    reset,
  input  logic                                    video_field_end,
  input  logic [CNT_W-1:0]                        blank_remaining,
  input  logic [NUM_SRC-1:0]                      req,
  output logic                                    preamble,
  output logic                                    guard,
  output logic                                    packet_enable,
  output logic [4:0]                              packet_pixel_counter,
  output logic [(NUM_SRC > 1 ? $clog2(NUM_SRC) : 1)-1:0] packet_sel,
  output logic [NUM_SRC-1:0]                      done,
  output logic [NUM_SRC-1:0]                      pending
);

  localparam int SEL_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int GAP_W = $clog2(MIN_GAP + 1);
  localparam int PKT_W = $clog2(MAX_PACKETS + 1);

  // A fresh island needs room for preamble, lead guard, one packet and trail guard.
  localparam logic [CNT_W-1:0] START_NEED = CNT_W'(44);
  localparam logic [CNT_W-1:0] NEXT_NEED  = CNT_W'(34);
  localparam logic [GAP_W-1:0] GAP_MAX    = GAP_W'(MIN_GAP);
  localparam logic [PKT_W-1:0] PKT_MAX    = PKT_W'(MAX_PACKETS);

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    LEAD_GUARD,
    PACKET,
    TRAIL_GUARD
  } state_t;

  state_t             state_q, state_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [PKT_W-1:0]   pktCnt_q, pktCnt_d;
  logic [GAP_W-1:0]   gap_q, gap_d;
  logic [NUM_SRC-1:0] pending_q, pending_d;

  logic               preamble_q, guard_q, pktEn_q;
  logic [4:0]         pixCnt_q;
  logic [SEL_W-1:0]   selOut_q;
  logic [NUM_SRC-1:0] done_q;

  function automatic logic [SEL_W-1:0] lowestIdx(input logic [NUM_SRC-1:0] v);
    lowestIdx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) lowestIdx = SEL_W'(i);
    end
  endfunction

  function automatic logic [NUM_SRC-1:0] oneHot(input logic [SEL_W-1:0] s);
    oneHot = '0;
    oneHot[s] = 1'b1;
  endfunction

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    sel_d    = sel_q;
    pktCnt_d = pktCnt_q;
    gap_d    = gap_q;
    // done_q is high exactly on the finishing packet's last cycle; new requests win.
    pending_d = (pending_q & ~done_q) | req | (video_field_end ? FIELD_MASK : '0);

    case (state_q)
      IDLE: begin
        if (gap_q != GAP_MAX) gap_d = gap_q + 1'b1;
        if (pending_q != '0 && gap_q == GAP_MAX && blank_remaining >= START_NEED) begin
          state_d = PREAMBLE;
          cnt_d   = '0;
        end
      end
      PREAMBLE: begin
        if (cnt_q == 5'd7) begin
          state_d = LEAD_GUARD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      LEAD_GUARD: begin
        if (cnt_q == 5'd1) begin
          state_d  = PACKET;
          cnt_d    = '0;
          sel_d    = lowestIdx(pending_q);
          pktCnt_d = PKT_W'(1);
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      PACKET: begin
        if (cnt_q == 5'd31) begin
          if (pending_d != '0 && pktCnt_q < PKT_MAX && blank_remaining >= NEXT_NEED) begin
            cnt_d    = '0;
            sel_d    = lowestIdx(pending_d);
            pktCnt_d = pktCnt_q + 1'b1;
          end else begin
            state_d = TRAIL_GUARD;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      TRAIL_GUARD: begin
        if (cnt_q == 5'd1) begin
          state_d = IDLE;
          cnt_d   = '0;
          gap_d   = '0;
        end else begin
          cnt_d = cnt_q + 5'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from next-state so they line up with the state register.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      sel_q      <= '0;
      pktCnt_q   <= '0;
      gap_q      <= GAP_MAX;
      pending_q  <= '0;
      preamble_q <= 1'b0;
      guard_q    <= 1'b0;
      pktEn_q    <= 1'b0;
      pixCnt_q   <= '0;
      selOut_q   <= '0;
      done_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sel_q      <= sel_d;
      pktCnt_q   <= pktCnt_d;
      gap_q      <= gap_d;
      pending_q  <= pending_d;
      preamble_q <= (state_d == PREAMBLE);
      guard_q    <= (state_d == LEAD_GUARD) || (state_d == TRAIL_GUARD);
      pktEn_q    <= (state_d == PACKET);
      pixCnt_q   <= (state_d == PACKET) ? cnt_d : '0;
      selOut_q   <= (state_d == PACKET) ? sel_d : '0;
      done_q     <= (state_d == PACKET && cnt_d == 5'd31) ? oneHot(sel_d) : '0;
    end
  end

  assign preamble             = preamble_q;
  assign guard                = guard_q;
  assign packet_enable        = pktEn_q;
  assign packet_pixel_counter = pixCnt_q;
  assign packet_sel           = selOut_q;
  assign done                 = done_q;
  assign pending              = pending_q;

endmodule
